// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param_if
//  Purpose  : Bundles the host-side and line-side signals of the UART
//             transmitter so that the transmitter and its driver connect
//             through one port.
//  Signals  : s_tick       - oversampling enable from the baud generator
//             tx_start     - request to send d_in
//             d_in         - word to transmit (DATA_BITS wide)
//             tx           - serial line, idles high
//             tx_busy      - frame in progress
//             tx_done_tick - one-clk pulse at end of the stop period
//  Modports : master - drives s_tick/tx_start/d_in, observes the rest
//             slave  - the transmitter itself
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 s_tick;
  logic                 tx_start;
  logic [DATA_BITS-1:0] d_in;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done_tick;

  modport master (
    output s_tick,
    output tx_start,
    output d_in,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  s_tick,
    input  tx_start,
    input  d_in,
    output tx,
    output tx_busy,
    output tx_done_tick
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param
//  Purpose  : Parametrised UART transmitter. Serialises a DATA_BITS word
//             LSB first between a start bit and a STOP_TICKS-long stop
//             period. All bit timing counts pulses of the oversampling tick.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - uart_tx_param_if.slave (s_tick, tx_start, d_in,
//                     tx, tx_busy, tx_done_tick)
//  Options  : UART_TX_PARITY_EN - when defined, a parity bit (even, or odd
//             when PARITY_ODD = 1) follows the last data bit.
//  Note     : the interface instance must be built with the same DATA_BITS.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_ODD = 0
) (
  input  wire                   clk,
  input  wire                   rst_n,
  uart_tx_param_if.slave        bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range guards
  // --------------------------------------------------------------------------
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_oversample
    $error("uart_tx_param: OVERSAMPLE must be 4..32");
  end
  if (STOP_TICKS < 1 || STOP_TICKS > 64) begin : g_bad_stop_ticks
    $error("uart_tx_param: STOP_TICKS must be 1..64");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  // --------------------------------------------------------------------------
  // Counter widths and terminal counts
  // --------------------------------------------------------------------------
  localparam int S_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = $clog2(DATA_BITS);

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  // Parity is taken from d_in at acceptance because b_q is consumed by
  // shifting as the data bits go out.
  logic                 par_q, par_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // tx_d is decoded from the current state, so the line follows the FSM
    // one clk later: tx falls on the edge after the accepting edge.
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_start) begin
          b_d     = bus.d_in;
          s_d     = '0;
          n_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^bus.d_in) ^ 1'(PARITY_ODD);
`endif
        end
      end

      ST_START: begin
        tx_d = 1'b0;
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        tx_d = b_q[0];
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              n_d     = '0;
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q;
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (bus.s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = '0;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_param
//  Purpose  : Scoreboard bench for uart_tx_param. Two instances: dut0 with
//             default parameters and s_tick every clk, dut1 with
//             DATA_BITS = 7, STOP_TICKS = 32, PARITY_ODD = 1 and s_tick
//             every 4th clk. Stimulus pushes the expected frame; a monitor
//             on the selected instance decodes the line and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(7)) if1 ();

  uart_tx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(16), .PARITY_ODD(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );

  uart_tx_param #(
    .DATA_BITS(7), .OVERSAMPLE(16), .STOP_TICKS(32), .PARITY_ODD(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  // s_tick for dut1: one pulse every 4 clk
  logic [1:0] div = 2'd0;
  always @(posedge clk) div <= div + 2'd1;
  assign if1.s_tick = (div == 2'd3);

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [15:0] bits;      // line value per bit slot: start, data, [parity]
    int          nbits;
    int          bit_clks;
    int          stop_clks;
    int          len;       // clks from accepting edge to done edge
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests  = 0;
  int   failed = 0;
  bit   sel    = 1'b0;      // 0: monitor dut0, 1: monitor dut1
  bit   in_frame = 1'b0;

  logic m_tx, m_busy, m_done;
  always_comb begin
    m_tx   = sel ? if1.tx           : if0.tx;
    m_busy = sel ? if1.tx_busy      : if0.tx_busy;
    m_done = sel ? if1.tx_done_tick : if0.tx_done_tick;
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected frame for a 16x oversampled transmitter.
  function automatic exp_t mk_exp(input logic [15:0] data, input int db,
                                  input int odd, input int period,
                                  input int stop_ticks);
    exp_t e;
    logic p;
    e.bits = '0;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      e.bits[i+1] = data[i];
      p = p ^ data[i];
    end
    e.nbits = db + 1;
`ifdef UART_TX_PARITY_EN
    e.bits[db+1] = p ^ odd[0];
    e.nbits = db + 2;
`else
    if (odd < 0) e.bits[15] = p;  // parity not part of the frame
`endif
    e.bit_clks  = 16 * period;
    e.stop_clks = stop_ticks * period;
    e.len       = (16 * e.nbits + stop_ticks) * period;
    return e;
  endfunction

  // Monitor: detect the start bit, sample mid-bit, check stop level,
  // frame length, busy length and the done pulse.
  initial begin : monitor
    int  t;
    int  busy_cnt;
    bit  prev_tx, prev_busy, prev_done;
    t = 0; busy_cnt = 0; prev_tx = 1'b1; prev_busy = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0; busy_cnt = 0;
        prev_tx = 1'b1; prev_busy = 1'b0; prev_done = 1'b0;
      end else begin
        if (m_busy) busy_cnt++;
        else if (prev_busy) begin
          chk(busy_cnt == cur.len, "busy_len", busy_cnt, cur.len);
          busy_cnt = 0;
        end
        if (m_done)
          chk(in_frame && !prev_done, "done_pulse", int'(prev_done), 0);
        if (!in_frame) begin
          if (prev_tx && !m_tx) begin
            if (q.size() == 0) chk(1'b0, "spurious_frame", 1, 0);
            else begin
              cur = q.pop_front();
              in_frame = 1'b1;
              t = 0;
            end
          end
        end else begin
          t++;
        end
        if (in_frame) begin
          if (t < cur.nbits * cur.bit_clks && (t % cur.bit_clks) == cur.bit_clks / 2)
            chk(m_tx == cur.bits[t / cur.bit_clks],
                $sformatf("bit%0d", t / cur.bit_clks), int'(m_tx),
                int'(cur.bits[t / cur.bit_clks]));
          if (t == cur.nbits * cur.bit_clks + cur.stop_clks / 2)
            chk(m_tx == 1'b1, "stop_level", int'(m_tx), 1);
          if (m_done) begin
            chk(t == cur.len - 1, "frame_len", t, cur.len - 1);
            in_frame = 1'b0;
          end else if (t > cur.len + 16) begin
            chk(1'b0, "done_timeout", t, cur.len - 1);
            in_frame = 1'b0;
          end
        end
        prev_tx = m_tx; prev_busy = m_busy; prev_done = m_done;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send0(input logic [7:0] data, input bit hold);
    q.push_back(mk_exp({8'h00, data}, 8, 0, 1, 16));
    @(posedge clk); #1;
    if0.d_in = data; if0.tx_start = 1'b1;
    if (!hold) begin
      @(posedge clk); #1;
      if0.tx_start = 1'b0;
      if0.d_in = ~data;       // must not disturb the captured word
    end
  endtask

  // Raise tx_start so the accepting edge coincides with a tick edge.
  task automatic send1(input logic [6:0] data);
    int k;
    q.push_back(mk_exp({9'h000, data}, 7, 1, 4, 32));
    k = 0;
    do begin @(negedge clk); k++; end while (!if1.s_tick && k < 8);
    if1.d_in = data; if1.tx_start = 1'b1;
    @(posedge clk); #1;
    if1.tx_start = 1'b0;
    if1.d_in = ~data;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while ((m_busy || in_frame) && k < bound);
    if (k >= bound) chk(1'b0, "idle_timeout", k, bound);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin : stim
    int k;
    if0.s_tick = 1'b1; if0.tx_start = 1'b0; if0.d_in = '0;
    if1.tx_start = 1'b0; if1.d_in = '0;

    // 1. reset and idle
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({if0.tx, if0.tx_busy, if0.tx_done_tick} == 3'b100, "reset_idle0",
          int'({if0.tx, if0.tx_busy, if0.tx_done_tick}), 4);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({if0.tx, if0.tx_busy, if0.tx_done_tick} == 3'b100, "idle0",
          int'({if0.tx, if0.tx_busy, if0.tx_done_tick}), 4);
      chk({if1.tx, if1.tx_busy, if1.tx_done_tick} == 3'b100, "idle1",
          int'({if1.tx, if1.tx_busy, if1.tx_done_tick}), 4);
    end

    // 2. basic frame
    send0(8'hA5, 1'b0);
    wait_idle(300);

    // 3. start ignored while busy, then back-to-back
    send0(8'h96, 1'b0);
    repeat (40) @(posedge clk);
    #1 if0.d_in = 8'hFF; if0.tx_start = 1'b1;
    @(posedge clk); #1 if0.tx_start = 1'b0;
    repeat (100) @(posedge clk);
    q.push_back(mk_exp(16'h003C, 8, 0, 1, 16));
    #1 if0.d_in = 8'h3C; if0.tx_start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!if0.tx_done_tick && k < 300);
    chk(if0.tx_done_tick == 1'b1, "b2b_done_seen", int'(if0.tx_done_tick), 1);
    @(posedge clk); #1 if0.tx_start = 1'b0; if0.d_in = 8'h00;
    @(negedge clk);
    chk(if0.tx == 1'b1, "b2b_gap_high", int'(if0.tx), 1);
    @(negedge clk);
    chk(if0.tx == 1'b0, "b2b_start", int'(if0.tx), 0);
    wait_idle(300);

    // 4. reset during data bit 3
    send0(8'hC3, 1'b0);
    repeat (16 * 4 + 8) @(posedge clk);
    #1 chk(if0.tx == 1'b0, "pre_reset_bit3", int'(if0.tx), 0);
    #1 rst_n = 1'b0;
    #1 chk({if0.tx, if0.tx_busy, if0.tx_done_tick} == 3'b100, "async_reset",
           int'({if0.tx, if0.tx_busy, if0.tx_done_tick}), 4);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send0(8'h55, 1'b0);
    wait_idle(300);

    // 6. parity vector (parity bit present only with the feature built in)
    send0(8'h07, 1'b0);
    wait_idle(300);

    // 5. DATA_BITS = 7, STOP_TICKS = 32, s_tick every 4th clk
    sel = 1'b1;
    repeat (2) @(posedge clk);
    send1(7'h41);
    wait_idle(900);
    send1(7'h07);
    wait_idle(900);

    repeat (5) @(posedge clk);
    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, next generation of the fixed 8N1 transmitter.
- Serialises a DATA_BITS-wide word onto `tx`, LSB first, framed by a start bit and a configurable stop period.
- All bit timing is derived from the oversampling tick `s_tick` produced by the baud-rate generator.
- Sits between the host-side byte source (or a TX FIFO) and the pad.
- Adds what the previous block lacks: a proper busy/done handshake, an asynchronous reset, and an optional parity bit.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: `s_tick` pulses per bit period for the start, data and parity bits; legal range 4..32.
- STOP_TICKS, 16: `s_tick` pulses in the stop period; 16 = 1 stop, 24 = 1.5 stop, 32 = 2 stop (with OVERSAMPLE = 16); legal range 1..64.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- s_tick, input, 1: oversampling enable; one-clk-wide pulse, OVERSAMPLE pulses per bit.
- tx_start, input, 1: request to send `d_in`; sampled only in IDLE.
- d_in, input, DATA_BITS: word to transmit; captured on the accepting edge.
- tx, output, 1: serial line, registered; idles high.
- tx_busy, output, 1: high from the accepting edge until the frame ends.
- tx_done_tick, output, 1: one-clk pulse when the stop period completes.

Behaviour:
Reset:
- `rst_n` low immediately forces: `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0, state = IDLE, all counters = 0.
- Assertion mid-frame aborts the frame; the line returns high at once.
- Operation resumes on the first clk edge after `rst_n` deasserts.

Registers:
- state, tick counter `s` (width $clog2 of max(OVERSAMPLE, STOP_TICKS)), bit counter `n` ($clog2(DATA_BITS)), shift register `b` (DATA_BITS), `tx` register.
- Fully synchronous single-process next-state update; no combinational latches.
- `s` and `n` never wrap: each is cleared on every state exit.

States:
- IDLE:
  - `tx` = 1, `tx_busy` = 0.
  - If `tx_start` = 1: `b` <= `d_in`, `s` <= 0, go to START, `tx_busy` <= 1.
  - Acceptance does not wait for `s_tick`.
- START:
  - `tx` = 0.
  - On each `s_tick`: if `s` == OVERSAMPLE-1, then `s` <= 0, `n` <= 0, go to DATA; else `s` <= `s`+1.
- DATA:
  - `tx` = `b[0]`.
  - On `s_tick` with `s` == OVERSAMPLE-1: `s` <= 0, `b` <= `b` >> 1.
  - Then if `n` == DATA_BITS-1, go to PARITY (feature on) or STOP (feature off); else `n` <= `n`+1.
- PARITY (feature on only):
  - `tx` = parity bit, computed over the word captured in IDLE.
  - Lasts OVERSAMPLE ticks, then go to STOP.
- STOP:
  - `tx` = 1.
  - On `s_tick` with `s` == STOP_TICKS-1: go to IDLE, `tx_busy` <= 0, `tx_done_tick` <= 1 for exactly one clk.

Latency:
- `tx` falls on the clk edge after the accepting edge.
- Frame length in ticks = OVERSAMPLE × (1 + DATA_BITS [+1 if parity]) + STOP_TICKS.

Boundary conditions:
- `tx_start` while busy: ignored, no queuing.
- `d_in` changes after capture: no effect on the frame in flight.
- Back-to-back: `tx_start` held high through the `tx_done_tick` cycle is accepted in that same cycle, so the line stays high for exactly one clk before the next start bit.
- `s_tick` stuck low: the FSM holds its state and `tx` indefinitely.
- `s_tick` high every clk is legal: each tick counts.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after the last data bit.
  - Parity bit = XOR of the captured data word XOR PARITY_ODD.
  - Frame grows by OVERSAMPLE ticks.
- Undefined: no PARITY state, no parity logic; PARITY_ODD is ignored.

Test Plan:
1. Reset and idle: `rst_n` = 0 for 3 clk, then 1 with `s_tick` running -> `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0 throughout.
2. Basic 8N1 frame, `s_tick` every clk, `d_in` = 8'hA5, 1-clk `tx_start` ->
   - `tx` = 0 for 16 clk.
   - Then bits 1,0,1,0,0,1,0,1 (LSB first), 16 clk each.
   - Then 1 for 16 clk; `tx_done_tick` pulses exactly once.
   - `tx_busy` high for 160 clk.
3. Start ignored and back-to-back: `tx_start` pulsed mid-frame with `d_in` = 8'hFF -> no effect on the frame in flight. Then `tx_start` held high with 8'h3C -> second start bit begins 1 clk after `tx_done_tick`, and the 8'h3C frame is correct.
4. Reset mid-frame: `rst_n` low during data bit 3 -> `tx` = 1 and `tx_busy` = 0 asynchronously, before the next clk edge. A new 8'h55 frame afterwards is correct.
5. Parameter and tick variation: DATA_BITS = 7, STOP_TICKS = 32, `s_tick` every 4th clk, `d_in` = 7'h41 -> frame lasts (16×8 + 32)×4 = 640 clk; stop period = 128 clk.
6. Parity: UART_TX_PARITY_EN defined.
   - PARITY_ODD = 0, `d_in` = 8'h07 -> parity bit 1.
   - PARITY_ODD = 1, `d_in` = 8'h07 -> parity bit 0.
   - Both frames last 176 ticks.
